// File: rtl/inst_fetch_buffer.sv
`timescale 1ns/1ps
// ============================================================================
// inst_fetch_buffer
//
// Fetch stage in front of decode. Holds the PC, reads the combinational
// instruction ROM once per cycle while the queue has room, and stores each
// {pc, inst, addr_err} triple in a small FIFO. Decode drains the FIFO over a
// valid/ready handshake. A pipeline redirect flushes the FIFO and reloads the
// PC.
//
// A misaligned PC is never sent to the ROM. Instead a single error entry
// {pc, 0, err=1} is queued and fetching halts until the next redirect.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   rom_en          ROM read enable
//   rom_write_en    ROM byte write enables, tied to 0
//   rom_addr        ROM read address (current PC)
//   rom_write_data  ROM write data, tied to 0
//   rom_read_data   ROM read data, valid in the same cycle as rom_addr
//   redirect        pipeline redirect (branch/jump/exception)
//   redirect_pc     new fetch address while redirect is high
//   inst_valid      FIFO head valid
//   inst_ready      decode accepts the head this cycle
//   inst            head instruction word
//   inst_pc         head PC
//   inst_addr_err   head came from a misaligned PC (inst is 0)
// ============================================================================
module inst_fetch_buffer #(
    parameter logic [31:0] INIT_PC    = 32'hbfc00000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_en,
    output logic [3:0]  rom_write_en,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_write_data,
    input  logic [31:0] rom_read_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_addr_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // IDLE: first cycle after reset release, nothing issued yet.
    // RUN : fetching normally.
    // HALT: a misaligned-PC error entry has been queued; wait for redirect.
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

    fetch_state_t state, state_next;

    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] mem_pc   [FIFO_DEPTH];
    logic [31:0] mem_inst [FIFO_DEPTH];
    logic        mem_err  [FIFO_DEPTH];

    logic        fifo_nonempty;
    logic        pop;
    logic        room;
    logic        issue;
    logic        pc_aligned;
    logic        push;
    logic        push_err;
    logic [31:0] push_inst;

    // ------------------------------------------------------------------------
    // Fetch control and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        fifo_nonempty = (count != '0);
        inst_valid    = fifo_nonempty & ~redirect;
        pop           = inst_valid & inst_ready;
        // A simultaneous pop frees a slot, so a full FIFO can still accept.
        room          = (count != FULL_CNT) | pop;
        issue         = (state == FETCH_RUN) & room & ~redirect;
        pc_aligned    = (pc[1:0] == 2'b00);
        rom_en        = issue & pc_aligned;
        push          = issue;
        push_err      = issue & ~pc_aligned;
        push_inst     = push_err ? '0 : rom_read_data;

        unique case (state)
            FETCH_IDLE: state_next = FETCH_RUN;
            FETCH_RUN: begin
                if (push_err) begin
                    state_next = FETCH_HALT;
                end
            end
            FETCH_HALT: begin
                if (redirect) begin
                    state_next = FETCH_RUN;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= INIT_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (rom_en) begin
            pc <= pc + 32'd4;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy; redirect flushes everything
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head outputs are masked while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pc;
            mem_inst[wr_ptr] <= push_inst;
            mem_err[wr_ptr]  <= push_err;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rom_addr       = pc;
        rom_write_en   = '0;
        rom_write_data = '0;
        inst           = '0;
        inst_pc        = '0;
        inst_addr_err  = 1'b0;
        if (fifo_nonempty) begin
            inst          = mem_inst[rd_ptr];
            inst_pc       = mem_pc[rd_ptr];
            inst_addr_err = mem_err[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
`timescale 1ns/1ps
// Testbench for inst_fetch_buffer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_inst_fetch_buffer;

    localparam logic [31:0] INIT_PC    = 32'hbfc00000;
    localparam int          FIFO_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        rom_en;
    logic [3:0]  rom_write_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_write_data;
    logic [31:0] rom_read_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_addr_err;

    inst_fetch_buffer #(
        .INIT_PC   (INIT_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_en        (rom_en),
        .rom_write_en  (rom_write_en),
        .rom_addr      (rom_addr),
        .rom_write_data(rom_write_data),
        .rom_read_data (rom_read_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_addr_err (inst_addr_err)
    );

    // ROM model: every word holds its own address.
    assign rom_read_data = rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a plain queue of fetched entries plus PC and flags
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_active;
    logic        m_halt;

    function automatic logic m_pop();
        return (mq.size() != 0) && !redirect && inst_ready;
    endfunction

    function automatic logic m_issue();
        logic room;
        room = (mq.size() < FIFO_DEPTH) || m_pop();
        return m_active && room && !redirect && !m_halt;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = INIT_PC;
        m_active = 1'b0;
        m_halt   = 1'b0;
    endtask

    task automatic model_check();
        logic        e_en;
        logic [31:0] e_inst, e_pc;
        logic        e_err;
        e_en   = m_issue() && (m_pc[1:0] == 2'b00);
        e_inst = 32'h0;
        e_pc   = 32'h0;
        e_err  = 1'b0;
        if (mq.size() != 0) begin
            e_inst = mq[0].word;
            e_pc   = mq[0].pc;
            e_err  = mq[0].err;
        end
        chk("rom_en", {31'b0, rom_en}, {31'b0, e_en});
        chk("rom_addr", rom_addr, m_pc);
        chk("rom_write_en", {28'b0, rom_write_en}, 32'h0);
        chk("rom_write_data", rom_write_data, 32'h0);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, (mq.size() != 0) && !redirect});
        chk("inst", inst, e_inst);
        chk("inst_pc", inst_pc, e_pc);
        chk("inst_addr_err", {31'b0, inst_addr_err}, {31'b0, e_err});
    endtask

    task automatic model_update();
        logic p, is;
        ent_t e;
        if (!rst_n) return;
        p  = m_pop();
        is = m_issue();
        if (redirect) begin
            mq.delete();
            m_pc   = redirect_pc;
            m_halt = 1'b0;
        end else begin
            if (p) void'(mq.pop_front());
            if (is) begin
                if (m_pc[1:0] == 2'b00) begin
                    e.pc = m_pc; e.word = m_pc; e.err = 1'b0;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end else begin
                    e.pc = m_pc; e.word = 32'h0; e.err = 1'b1;
                    mq.push_back(e);
                    m_halt = 1'b1;
                end
            end
        end
        m_active = 1'b1;
    endtask

    // Cycle helpers: inputs change just after the rising edge, outputs are
    // sampled on the falling edge.
    task automatic step_begin(input logic rdy, input logic redir, input logic [31:0] rpc);
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(negedge clk);
        model_check();
    endtask

    task automatic step_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        step_begin(rdy, redir, rpc);
        step_end();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        restart;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_ipc;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] exp_next;
    logic        seq_on;

    initial begin
        rst_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();

        // Release with inst_ready=1: one idle cycle, then a steady stream.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hbfc00000, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00000});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00004});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00008});
        // inst_ready=0: four pushes fill the FIFO, then fetch stalls at ..10.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hbfc00000, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hbfc00010, 1'b1, 32'hbfc00000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hbfc00010, 1'b1, 32'hbfc00000});
        // Ready rises while full: push and pop together.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00010, 1'b1, 32'hbfc00000});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00014, 1'b1, 32'hbfc00004});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00018, 1'b1, 32'hbfc00008});

        foreach (vecs[i]) begin
            if (vecs[i].restart) do_reset();
            step_begin(vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            chk("tbl_rom_en", {31'b0, rom_en}, {31'b0, vecs[i].exp_en});
            chk("tbl_rom_addr", rom_addr, vecs[i].exp_addr);
            chk("tbl_inst_valid", {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
            chk("tbl_inst_pc", inst_pc, vecs[i].exp_ipc);
            step_end();
        end

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step_begin(1'b1, 1'b1, 32'hbfc00100);
        chk("redir_valid", {31'b0, inst_valid}, 32'h0);
        chk("redir_rom_en", {31'b0, rom_en}, 32'h0);
        step_end();
        step_begin(1'b1, 1'b0, 32'h0);
        chk("redir_addr", rom_addr, 32'hbfc00100);
        chk("redir_issue", {31'b0, rom_en}, 32'h1);
        step_end();
        step_begin(1'b1, 1'b0, 32'h0);
        chk("redir_head_valid", {31'b0, inst_valid}, 32'h1);
        chk("redir_head_pc", inst_pc, 32'hbfc00100);
        step_end();

        // Misaligned redirect target.
        step(1'b0, 1'b1, 32'hbfc00102);
        step_begin(1'b0, 1'b0, 32'h0);
        chk("mis_rom_en0", {31'b0, rom_en}, 32'h0);
        step_end();
        step_begin(1'b0, 1'b0, 32'h0);
        chk("mis_valid", {31'b0, inst_valid}, 32'h1);
        chk("mis_err", {31'b0, inst_addr_err}, 32'h1);
        chk("mis_inst", inst, 32'h0);
        chk("mis_pc", inst_pc, 32'hbfc00102);
        chk("mis_rom_en1", {31'b0, rom_en}, 32'h0);
        step_end();
        step_begin(1'b1, 1'b0, 32'h0);
        chk("mis_rom_en_pop", {31'b0, rom_en}, 32'h0);
        step_end();
        step_begin(1'b0, 1'b0, 32'h0);
        chk("mis_empty", {31'b0, inst_valid}, 32'h0);
        chk("mis_halted", {31'b0, rom_en}, 32'h0);
        step_end();
        step(1'b0, 1'b1, 32'hbfc00200);
        step_begin(1'b0, 1'b0, 32'h0);
        chk("resume_en", {31'b0, rom_en}, 32'h1);
        chk("resume_addr", rom_addr, 32'hbfc00200);
        step_end();

        // Asynchronous reset mid-stream with entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rom_en", {31'b0, rom_en}, 32'h0);
        chk("arst_valid", {31'b0, inst_valid}, 32'h0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_err", {31'b0, inst_addr_err}, 32'h0);
        chk("arst_pc", rom_addr, INIT_PC);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step_begin(1'b1, 1'b0, 32'h0);
        chk("arst_restart_pc", inst_pc, INIT_PC);
        chk("arst_restart_valid", {31'b0, inst_valid}, 32'h1);
        step_end();

        // Randomized traffic; also track PC continuity of popped entries.
        do_reset();
        exp_next = INIT_PC;
        seq_on   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic        rdy, redir;
            logic [31:0] rpc;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 39) == 0);
            rpc   = 32'hbfc00000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) rpc = 32'hfffffff8;
            step_begin(rdy, redir, rpc);
            if (inst_valid && inst_ready) begin
                if (!inst_addr_err) chk("rnd_inst_eq_pc", inst, inst_pc);
                if (seq_on) chk("rnd_pc_sequence", inst_pc, exp_next);
                if (!inst_addr_err) exp_next = inst_pc + 32'd4;
            end
            if (redir) exp_next = rpc;
            step_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
